// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and helpers for the seq_det_sched scheduler.
//   - state_e        : scheduler FSM states
//   - *_DEF          : default NREQ / PAT_W / BURST
//   - rr_pick_onehot : circular first-set-bit pick starting at a pointer
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int PAT_W_DEF = 4;
  localparam int BURST_DEF = 8;

  // Widest requester vector the pick helper supports.
  localparam int RR_MAX = 8;

  // One-hot of the first set bit of req at or after ptr, wrapping modulo n.
  // Only bits [n-1:0] of req are looked at; the result is zero if none set.
  function automatic logic [RR_MAX-1:0] rr_pick_onehot(
    input logic [RR_MAX-1:0] req,
    input int                ptr,
    input int                n
  );
    logic [RR_MAX-1:0] pick;
    logic              found;
    logic [2:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = 3'((ptr + k) % n);
      if ((k < n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// seq_det_rr_arb
//   Round-robin pick over NREQ level requests plus the rotating priority
//   pointer. The pick is combinational; the pointer moves to one past the
//   index given on adv_idx_i when adv_i is high.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : request vector
//   adv_i        : advance pointer this cycle
//   adv_idx_i    : index that just finished; pointer becomes adv_idx_i+1
//   any_o        : at least one request is pending
//   pick_oh_o    : one-hot winner
//   pick_idx_o   : binary index of winner
module seq_det_rr_arb
  import seq_det_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  input  logic [IW-1:0]   adv_idx_i,
  output logic            any_o,
  output logic [NREQ-1:0] pick_oh_o,
  output logic [IW-1:0]   pick_idx_o
);

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    pick_ext            = rr_pick_onehot(req_ext, int'(rr_ptr_q), NREQ);
    pick_oh_o           = pick_ext[NREQ-1:0];
    // The pick is non-zero exactly when some request is set.
    any_o               = |pick_ext;
    pick_idx_o          = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_ext[i]) pick_idx_o = IW'(i);
    end
    rr_ptr_d = rr_ptr_q;
    if (adv_i) begin
      rr_ptr_d = (adv_idx_i == IW'(NREQ - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched
//   Time-shares one programmable serial pattern detector between NREQ
//   serial-bit requesters. A granted requester streams BURST bits; the block
//   pulses match_o per detected pattern and reports the per-burst count.
//
//   state | meaning
//   IDLE  | clear datapath, accept pattern writes, grant next requester
//   RUN   | accept bits from the granted lane, shift/compare, count matches
//   DONE  | one cycle: done_o/done_id_o/match_cnt_o valid, advance rr pointer
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_i        : per-requester burst request (level)
//   gnt_o        : registered one-hot grant
//   bit_vld_i/bit_i/bit_rdy_o : per-lane serial handshake
//   cfg_we_i, pattern_i : pattern load (IDLE only), MSB = oldest bit
//   match_o      : one-cycle pulse per match
//   done_o, done_id_o, match_cnt_o : end-of-burst report
//   timeout_o    : burst aborted by stall (SEQDET_TIMEOUT_EN only)
//
// Optional build macro: SEQDET_TIMEOUT_EN adds parameter TIMEOUT and port
// timeout_o; a burst with TIMEOUT consecutive bit-less cycles is aborted.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int BURST = BURST_DEF,
  parameter int CNT_W = $clog2(BURST + 1)
`ifdef SEQDET_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  input  logic [NREQ-1:0]         bit_vld_i,
  input  logic [NREQ-1:0]         bit_i,
  output logic [NREQ-1:0]         bit_rdy_o,
  input  logic                    cfg_we_i,
  input  logic [PAT_W-1:0]        pattern_i,
  output logic                    match_o,
  output logic                    done_o,
  output logic [$clog2(NREQ)-1:0] done_id_o,
  output logic [CNT_W-1:0]        match_cnt_o
`ifdef SEQDET_TIMEOUT_EN
  , output logic                  timeout_o
`endif
);

  localparam int IW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic [IW-1:0]    done_id_q, done_id_d;
  logic             accept, hit, end_burst;

  logic             arb_any;
  logic [NREQ-1:0]  arb_oh;
  logic [IW-1:0]    arb_idx;

`ifdef SEQDET_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]    stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  seq_det_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .adv_i      (state_q == DONE),
    .adv_idx_i  (gidx_q),
    .any_o      (arb_any),
    .pick_oh_o  (arb_oh),
    .pick_idx_o (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    hist_d      = hist_q;
    pattern_d   = pattern_q;
    bcnt_d      = bcnt_q;
    mcnt_d      = mcnt_q;
    match_cnt_d = match_cnt_q;
    done_id_d   = done_id_q;
    match_d     = 1'b0;
    done_d      = 1'b0;
    accept      = 1'b0;
    hit         = 1'b0;
    end_burst   = 1'b0;
`ifdef SEQDET_TIMEOUT_EN
    stall_d     = stall_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        hist_d = '0;
        bcnt_d = '0;
        mcnt_d = '0;
`ifdef SEQDET_TIMEOUT_EN
        stall_d = '0;
`endif
        // A write landing with the grant decision applies to that burst.
        if (cfg_we_i) pattern_d = pattern_i;
        if (arb_any) begin
          gnt_d   = arb_oh;
          gidx_d  = arb_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        accept = bit_vld_i[gidx_q] & gnt_q[gidx_q];
        if (accept) begin
          hist_d = {hist_q[PAT_W-2:0], bit_i[gidx_q]};
          bcnt_d = bcnt_q + 1'b1;
          // The cleared history could alias the pattern before PAT_W bits.
          hit    = (hist_d == pattern_q) && (bcnt_d >= CNT_W'(PAT_W));
          if (hit) begin
            match_d = 1'b1;
            if (mcnt_q != CNT_W'(BURST)) mcnt_d = mcnt_q + 1'b1;
          end
          if (bcnt_d == CNT_W'(BURST)) end_burst = 1'b1;
        end
`ifdef SEQDET_TIMEOUT_EN
        stall_d = accept ? '0 : stall_q + 1'b1;
        if (!accept && (stall_d == SW'(TIMEOUT))) begin
          end_burst = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (end_burst) begin
          state_d     = DONE;
          gnt_d       = '0;
          done_d      = 1'b1;
          done_id_d   = gidx_q;
          match_cnt_d = mcnt_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      hist_q      <= '0;
      pattern_q   <= '1;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
`ifdef SEQDET_TIMEOUT_EN
      stall_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      hist_q      <= hist_d;
      pattern_q   <= pattern_d;
      bcnt_q      <= bcnt_d;
      mcnt_q      <= mcnt_d;
      match_cnt_q <= match_cnt_d;
      match_q     <= match_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
`ifdef SEQDET_TIMEOUT_EN
      stall_q     <= stall_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign bit_rdy_o   = (state_q == RUN) ? gnt_q : '0;
  assign match_o     = match_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign match_cnt_o = match_cnt_q;
`ifdef SEQDET_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched
//   Randomised bench for seq_det_sched. A transaction-level model predicts
//   the grant winner (circular search from the rr pointer), and the match
//   stream / count from the list of accepted bits of each burst.
//   With SEQDET_TIMEOUT_EN defined the model also predicts stall aborts.
module tb_seq_det_sched;

  localparam int NREQ  = 4;
  localparam int PAT_W = 4;
  localparam int BURST = 8;
  localparam int CNT_W = $clog2(BURST + 1);
  localparam int IW    = $clog2(NREQ);
`ifdef SEQDET_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_i = '0;
  logic [NREQ-1:0]  gnt_o;
  logic [NREQ-1:0]  bit_vld_i = '0;
  logic [NREQ-1:0]  bit_i = '0;
  logic [NREQ-1:0]  bit_rdy_o;
  logic             cfg_we_i = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic             match_o;
  logic             done_o;
  logic [IW-1:0]    done_id_o;
  logic [CNT_W-1:0] match_cnt_o;
`ifdef SEQDET_TIMEOUT_EN
  logic             timeout_o;
`endif

  always #5 clk = ~clk;

  seq_det_sched #(
    .NREQ  (NREQ),
    .PAT_W (PAT_W),
    .BURST (BURST)
`ifdef SEQDET_TIMEOUT_EN
    , .TIMEOUT (TIMEOUT)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .bit_vld_i   (bit_vld_i),
    .bit_i       (bit_i),
    .bit_rdy_o   (bit_rdy_o),
    .cfg_we_i    (cfg_we_i),
    .pattern_i   (pattern_i),
    .match_o     (match_o),
    .done_o      (done_o),
    .done_id_o   (done_id_o),
    .match_cnt_o (match_cnt_o)
`ifdef SEQDET_TIMEOUT_EN
    , .timeout_o (timeout_o)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rr_m   = 0;
  logic [PAT_W-1:0] pat_m = '1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt_o), 0);
    chk({tag, "_rdy"},   32'(bit_rdy_o), 0);
    chk({tag, "_match"}, 32'(match_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
    chk({tag, "_id"},    32'(done_id_o), 0);
    chk({tag, "_cnt"},   32'(match_cnt_o), 0);
`ifdef SEQDET_TIMEOUT_EN
    chk({tag, "_tmo"},   32'(timeout_o), 0);
`endif
  endtask

  // Called at a negedge with the DUT idle.
  task automatic load_pattern(input logic [PAT_W-1:0] p);
    req_i     = '0;
    cfg_we_i  = 1'b1;
    pattern_i = p;
    pat_m     = p;
    @(negedge clk);
    cfg_we_i  = 1'b0;
  endtask

  // One full burst. mode 0: granted vld random with vld_pct; mode 1: granted
  // vld every other cycle, other lanes vld=1/bit=1; mode 2: two bits then
  // silence. Starts and ends at a negedge with the DUT idle.
  task automatic do_burst(input logic [NREQ-1:0] req, input int mode, input int vld_pct,
                          input logic fixed_en, input logic [BURST-1:0] fixed_bits,
                          input logic load_en, input logic [PAT_W-1:0] load_pat);
    int w, acc, stall, cyc, mcnt, v;
    int hist[$];
    logic exp_match, fin, tmo;
    req_i     = req;
    cfg_we_i  = load_en;
    pattern_i = load_en ? load_pat : PAT_W'($urandom);
    bit_vld_i = NREQ'($urandom);
    bit_i     = NREQ'($urandom);
    if (load_en) pat_m = load_pat;
    w = model_pick(req, rr_m);
    @(negedge clk);
    chk("gnt", 32'(gnt_o), 32'(1 << w));
    chk("rdy", 32'(bit_rdy_o), 32'(1 << w));
    acc = 0; stall = 0; cyc = 0; mcnt = 0; fin = 1'b0; tmo = 1'b0;
    hist.delete();
    while (!fin) begin
      req_i     = NREQ'($urandom);
      cfg_we_i  = 1'($urandom_range(1));
      pattern_i = ($urandom_range(1) == 1) ? '1 : PAT_W'($urandom);
      bit_vld_i = NREQ'($urandom);
      bit_i     = NREQ'($urandom);
      case (mode)
        1: begin
          bit_vld_i    = '1;
          bit_i        = '1;
          bit_vld_i[w] = (cyc % 2 == 1);
          bit_i[w]     = 1'($urandom_range(1));
        end
        2:       bit_vld_i[w] = (acc < 2);
        default: bit_vld_i[w] = ($urandom_range(99) < vld_pct);
      endcase
      if (fixed_en) bit_i[w] = fixed_bits[acc];
      exp_match = 1'b0;
      if (bit_vld_i[w]) begin
        hist.push_back(int'(bit_i[w]));
        acc++;
        stall = 0;
        if (acc >= PAT_W) begin
          v = 0;
          for (int j = 0; j < PAT_W; j++) v = v * 2 + hist[acc - PAT_W + j];
          exp_match = (v == int'(pat_m));
        end
        if (exp_match && mcnt < BURST) mcnt++;
        if (acc == BURST) fin = 1'b1;
      end else begin
        stall++;
`ifdef SEQDET_TIMEOUT_EN
        if (stall == TIMEOUT) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
`endif
      end
      cyc++;
      @(negedge clk);
      chk("match", 32'(match_o), 32'(exp_match));
      chk("done",  32'(done_o), 32'(fin));
`ifdef SEQDET_TIMEOUT_EN
      chk("timeout", 32'(timeout_o), 32'(tmo));
`endif
      if (fin) begin
        chk("done_id",   32'(done_id_o), 32'(w));
        chk("match_cnt", 32'(match_cnt_o), 32'(mcnt));
        chk("gnt_done",  32'(gnt_o), 0);
        chk("rdy_done",  32'(bit_rdy_o), 0);
      end else begin
        chk("gnt_run", 32'(gnt_o), 32'(1 << w));
        chk("rdy_run", 32'(bit_rdy_o), 32'(1 << w));
        if (cyc > 400) begin
          chk("burst_bound", 32'(done_o), 1);
          return;
        end
      end
    end
    req_i     = '0;
    cfg_we_i  = 1'b0;
    bit_vld_i = NREQ'($urandom);
    @(negedge clk);
    chk("idle_gnt",   32'(gnt_o), 0);
    chk("idle_done",  32'(done_o), 0);
    chk("idle_match", 32'(match_o), 0);
    chk("cnt_hold",   32'(match_cnt_o), 32'(mcnt));
    rr_m = (w + 1) % NREQ;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Pattern 1011, requester 0 streams 1,0,1,1,0,1,1,0: matches on bits 4 and 7.
    load_pattern(4'b1011);
    do_burst(4'b0001, 0, 100, 1'b1, 8'b0110_1101, 1'b0, '0);
    chk("plan_cnt2", 32'(match_cnt_o), 2);

    // All requesting: rotation with two idle cycles between grants.
    for (int i = 0; i < 5; i++) do_burst(4'b1111, 0, 100, 1'b0, '0, 1'b0, '0);

    // Granted lane valid every other cycle, other lanes noisy.
    do_burst(4'b1111, 1, 0, 1'b0, '0, 1'b0, '0);

    // Pattern writes during RUN ignored (bench drives them every RUN cycle).
    do_burst(4'b0010, 0, 100, 1'b1, 8'b1101_1101, 1'b0, '0);
    chk("cfg_ignored_cnt", 32'(match_cnt_o), 2);
    load_pattern(4'b1111);
    do_burst(4'b0100, 0, 100, 1'b1, 8'hFF, 1'b0, '0);
    chk("ones_cnt", 32'(match_cnt_o), 5);

    // Reset after three accepted bits.
    req_i = 4'b0100;
    w = model_pick(4'b0100, rr_m);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 32'(1 << w));
    req_i = '0;
    for (int i = 0; i < 3; i++) begin
      bit_vld_i = '1;
      bit_i     = NREQ'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    rr_m  = 0;
    pat_m = '1;
    bit_vld_i = '0;
    @(negedge clk);
    chk("midrst_nodone", 32'(done_o), 0);
    do_burst(4'b1111, 0, 100, 1'b0, '0, 1'b0, '0);

    // Randomised bursts, pattern sometimes loaded together with the grant.
    for (int i = 0; i < 25; i++) begin
      do_burst(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 0, $urandom_range(40, 100),
               1'b0, '0, 1'($urandom_range(1)), PAT_W'($urandom));
    end

`ifdef SEQDET_TIMEOUT_EN
    load_pattern(4'b1011);
    do_burst(4'b1111, 2, 0, 1'b0, '0, 1'b0, '0);
    chk("tmo_cnt", 32'(match_cnt_o), 0);
    do_burst(4'b1111, 0, 100, 1'b0, '0, 1'b0, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
